// File: rtl/decode_pkg.sv
// decode_pkg: shared encodings and defaults for the decode stage.
// Revision 1.0
`default_nettype none

package decode_pkg;

   localparam int REG_ADDR_W       = 3;
   localparam int LINK_REG_DEFAULT = 7;

   typedef enum logic [1:0] {
      WSEL_7_5  = 2'b00,
      WSEL_4_2  = 2'b01,
      WSEL_10_8 = 2'b10,
      WSEL_LINK = 2'b11
   } wsel_e;

   typedef enum logic [1:0] {
      IMM_5    = 2'b00,
      IMM_8    = 2'b01,
      IMM_11   = 2'b10,
      IMM_ZERO = 2'b11
   } imm_len_e;

endpackage

`default_nettype wire

// File: rtl/regfile_bypass.sv
// regfile_bypass: register file, two combinational read ports, one write
// port with write-through bypass. Revision 1.0
`default_nettype none

module regfile_bypass
   import decode_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [REG_ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [REG_ADDR_W-1:0] raddr1_i,
   input  logic [REG_ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0]     rdata1_o,
   output logic [DATA_W-1:0]     rdata2_o
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Same-cycle write-back is forwarded so the decode sees the new value.
   assign rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
   assign rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// decode_stage: instruction decode with register read, immediate extension,
// destination select and ID/EX pipeline register. Revision 1.0
`default_nettype none

module decode_stage
   import decode_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int LINK_REG = LINK_REG_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [15:0]           instruc,
   input  logic [DATA_W-1:0]     seq_PC,
   input  logic [1:0]            w_reg_cont,
   input  logic                  ext_type,
   input  logic [1:0]            len_immed,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_reg,
   input  logic [DATA_W-1:0]     wb_data,
   output logic                  valid_out,
   output logic [DATA_W-1:0]     seq_PC_out,
   output logic [DATA_W-1:0]     ext_out,
   output logic [DATA_W-1:0]     data_1,
   output logic [DATA_W-1:0]     data_2,
   output logic [REG_ADDR_W-1:0] rs_out,
   output logic [REG_ADDR_W-1:0] rt_out,
   output logic [REG_ADDR_W-1:0] w_reg_out
);

   localparam logic [REG_ADDR_W-1:0] C_LINK_ADDR = REG_ADDR_W'(LINK_REG);

   logic [REG_ADDR_W-1:0] w_rs, w_rt, w_dest;
   logic [DATA_W-1:0]     w_imm, w_rdata1, w_rdata2;
   logic                  w_unused_opcode;

   logic                  valid_q, valid_d;
   logic [DATA_W-1:0]     pc_q, pc_d, ext_q, ext_d, d1_q, d1_d, d2_q, d2_d;
   logic [REG_ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, wr_q, wr_d;

   assign w_rs            = instruc[10:8];
   assign w_rt            = instruc[7:5];
   assign w_unused_opcode = ^instruc[15:11];

   regfile_bypass #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we_i     (wb_en),
      .waddr_i  (wb_reg),
      .wdata_i  (wb_data),
      .raddr1_i (w_rs),
      .raddr2_i (w_rt),
      .rdata1_o (w_rdata1),
      .rdata2_o (w_rdata2)
   );

   always_comb begin
      w_imm = '0;
      case (imm_len_e'(len_immed))
         IMM_5:    w_imm = {{(DATA_W-5){ext_type & instruc[4]}},   instruc[4:0]};
         IMM_8:    w_imm = {{(DATA_W-8){ext_type & instruc[7]}},   instruc[7:0]};
         IMM_11:   w_imm = {{(DATA_W-11){ext_type & instruc[10]}}, instruc[10:0]};
         default:  w_imm = '0;
      endcase
   end

   always_comb begin
      w_dest = instruc[7:5];
      case (wsel_e'(w_reg_cont))
         WSEL_7_5:  w_dest = instruc[7:5];
         WSEL_4_2:  w_dest = instruc[4:2];
         WSEL_10_8: w_dest = instruc[10:8];
         default:   w_dest = C_LINK_ADDR;
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      ext_d   = ext_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      wr_d    = wr_q;
      if (flush) begin
         valid_d = 1'b0;
         pc_d    = '0;
         ext_d   = '0;
         d1_d    = '0;
         d2_d    = '0;
         rs_d    = '0;
         rt_d    = '0;
         wr_d    = '0;
      end else if (stall) begin
         // A held instruction keeps tracking write-backs to its sources.
         if (wb_en && (wb_reg == rs_q)) d1_d = wb_data;
         if (wb_en && (wb_reg == rt_q)) d2_d = wb_data;
      end else begin
         valid_d = valid_in;
         pc_d    = seq_PC;
         ext_d   = w_imm;
         d1_d    = w_rdata1;
         d2_d    = w_rdata2;
         rs_d    = w_rs;
         rt_d    = w_rt;
         wr_d    = w_dest;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         ext_q   <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         wr_q    <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         ext_q   <= ext_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         wr_q    <= wr_d;
      end
   end

   assign valid_out  = valid_q;
   assign seq_PC_out = pc_q;
   assign ext_out    = ext_q;
   assign data_1     = d1_q;
   assign data_2     = d2_q;
   assign rs_out     = rs_q;
   assign rt_out     = rt_q;
   assign w_reg_out  = wr_q;

endmodule

`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 16, datapath and register width; SHALL be >= 16.
REQ-002 Parameter NUM_REGS, default 8, register count; register fields stay 3 bits, so it SHALL be 8.
REQ-003 Parameter LINK_REG, default 7, register selected when w_reg_cont = 2'b11.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 valid_in  input  1  instruc and seq_PC hold a live instruction.
REQ-007 stall  input  1  hold the ID/EX output register.
REQ-008 flush  input  1  replace the next captured instruction with a bubble.
REQ-009 instruc  input  16  instruction word.
REQ-010 seq_PC  input  DATA_W  PC+2 of instruc.
REQ-011 w_reg_cont  input  2  destination select: 00 instruc[7:5], 01 instruc[4:2], 10 instruc[10:8], 11 LINK_REG.
REQ-012 ext_type  input  1  1 = sign-extend, 0 = zero-extend.
REQ-013 len_immed  input  2  immediate source: 00 instruc[4:0], 01 instruc[7:0], 10 instruc[10:0], 11 constant zero.
REQ-014 wb_en, wb_reg[2:0], wb_data[DATA_W-1:0]  input  write-back port from the WB stage.
REQ-015 valid_out  output  1  ID/EX register holds a live instruction.
REQ-016 seq_PC_out, ext_out, data_1, data_2  output  DATA_W each  registered PC+2, immediate, rs value, rt value.
REQ-017 rs_out, rt_out, w_reg_out  output  3 each  registered instruc[10:8], instruc[7:5] and the selected destination.

Function
REQ-018 The register file SHALL have NUM_REGS entries of DATA_W bits, with two combinational read ports (rs, rt) and one write port.
REQ-019 The write port SHALL commit wb_data to wb_reg at the clock edge when wb_en = 1.
REQ-020 Write-through bypass: when wb_en = 1 and wb_reg equals a read address, that read port SHALL return wb_data in the same cycle.
REQ-021 The immediate SHALL be extended to DATA_W per ext_type; len_immed 11 SHALL yield all zeros.
REQ-022 When neither stall nor flush is asserted, all outputs SHALL capture the decoded values one cycle after presentation (latency 1), with valid_out <= valid_in.
REQ-023 When stall = 1 and flush = 0, every output SHALL hold, except that data_1 (data_2) SHALL load wb_data if wb_en = 1 and wb_reg == rs_out (rt_out).
REQ-024 flush SHALL take priority over stall: next cycle valid_out = 0 and all other outputs are 0.
REQ-025 When valid_in = 0 (and stall = 0), the stage SHALL still capture, with valid_out = 0; the register-file write port is unaffected.
REQ-026 Register-file writes SHALL occur regardless of stall, flush or valid_in.
REQ-027 Simultaneous write-back and decode of the same register SHALL deliver the new value in data_1/data_2 on the following cycle.
REQ-028 Read-before-write hazards across more than one stage are out of scope; the external hazard unit drives stall.

Reset
REQ-029 While rst = 1 at a clock edge, all registers and all outputs SHALL be zero, including valid_out = 0.
REQ-030 rst SHALL take priority over flush, stall and wb_en; a write-back in the reset cycle is discarded.
REQ-031 Reset asserted mid-stall SHALL clear the held instruction; the first capture after deassertion follows REQ-022.

Structure
REQ-032 Shared package decode_pkg SHALL hold the w_reg_cont encodings, the len_immed encodings and the LINK_REG default.
REQ-033 The register file with bypass SHALL be a sub-module, regfile_bypass, parametrised by DATA_W and NUM_REGS.
REQ-034 The extender and destination mux SHALL be combinational logic inside decode_stage feeding the ID/EX register.

Verification
REQ-035 Reset: hold rst 2 cycles with wb_en = 1 -> all outputs 0; reading r3 afterwards returns 0.
REQ-036 Write r2 = 16'h1234, then decode rs = r2 (instruc[10:8] = 3'b010) -> data_1 = 16'h1234 one cycle later.
REQ-037 In the same cycle, wb r5 = 16'hBEEF while decoding rt = r5 -> data_2 = 16'hBEEF next cycle (bypass).
REQ-038 Immediates: instruc[4:0] = 5'b10000, len 00, ext_type 1 -> ext_out = 16'hFFF0; same with ext_type 0 -> 16'h0010; len 11 -> 16'h0000.
REQ-039 Stall held 3 cycles with rs_out = 1, wb r1 = 16'h00AA during the stall -> data_1 = 16'h00AA, all other outputs unchanged.
REQ-040 flush and stall together with valid_in = 1 -> valid_out = 0 next cycle; w_reg_cont = 11 afterwards -> w_reg_out = 7.
